// File: rtl/bp_table_ctrl_pkg.sv
// bp_table_ctrl_pkg: shared widths, types and PC field helpers for the branch predictor tables.
package bp_table_ctrl_pkg;
  localparam int DBITS        = 32;
  localparam int PTINDEXBITS  = 8;
  localparam int BTBINDEXBITS = 6;
  localparam int TAGBITS      = 22;
  localparam int BHRBITS      = 8;
  localparam int MAXDEFER     = 4;
  localparam int PTENTRIES    = 1 << PTINDEXBITS;
  localparam int BTBENTRIES   = 1 << BTBINDEXBITS;
  localparam int DEFERBITS    = $clog2(MAXDEFER + 1);
  localparam logic [1:0] PT_INIT = 2'b01;
  typedef logic [DBITS-1:0]        addr_t;
  typedef logic [PTINDEXBITS-1:0]  pt_idx_t;
  typedef logic [BTBINDEXBITS-1:0] btb_idx_t;
  typedef logic [TAGBITS-1:0]      tag_t;
  typedef logic [BHRBITS-1:0]      bhr_t;
  typedef logic [DEFERBITS-1:0]    defer_t;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef struct packed {
    pt_idx_t  pt_idx;
    btb_idx_t btb_idx;
    tag_t     tag;
    logic     taken;
    addr_t    target;
  } upd_buf_t;
  function automatic btb_idx_t btb_idx_of(addr_t pc);
    return pc[BTBINDEXBITS+1:2];
  endfunction
  function automatic tag_t tag_of(addr_t pc);
    return pc[BTBINDEXBITS+TAGBITS+1:BTBINDEXBITS+2];
  endfunction
  function automatic pt_idx_t pt_base_of(addr_t pc);
    return pc[PTINDEXBITS+1:2];
  endfunction
endpackage

// File: rtl/bp_table_ctrl_if.sv
// bp_table_ctrl_if: FE lookup and AGEX update bus of the branch predictor tables.
interface bp_table_ctrl_if import bp_table_ctrl_pkg::*; ();
  logic     fe_req_valid;
  logic     fe_stall;
  addr_t    fe_pc;
  logic     pred_valid;
  logic     pred_taken;
  addr_t    pred_target;
  pt_idx_t  pred_pt_idx;
  btb_idx_t pred_btb_idx;
  logic     upd_valid;
  logic     upd_ready;
  addr_t    upd_pc;
  pt_idx_t  upd_pt_idx;
  logic     upd_taken;
  addr_t    upd_target;
  logic     init_busy;
  modport master (
    output fe_req_valid, fe_stall, fe_pc, upd_valid, upd_pc, upd_pt_idx, upd_taken, upd_target,
    input  pred_valid, pred_taken, pred_target, pred_pt_idx, pred_btb_idx, upd_ready, init_busy
  );
  modport slave (
    input  fe_req_valid, fe_stall, fe_pc, upd_valid, upd_pc, upd_pt_idx, upd_taken, upd_target,
    output pred_valid, pred_taken, pred_target, pred_pt_idx, pred_btb_idx, upd_ready, init_busy
  );
endinterface

// File: rtl/bp_table_ctrl_sat_counter2.sv
// bp_sat_counter2: next value of a 2-bit saturating up/down counter.
module bp_sat_counter2 (
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] nxt
);
  always_comb nxt = inc ? ((cnt == 2'b11) ? cnt : cnt + 2'd1) : ((cnt == 2'b00) ? cnt : cnt - 2'd1);
endmodule

// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: BHR, pattern table and BTB behind one shared port, arbitrating FE lookups
// against a single buffered AGEX update that may be deferred at most MAXDEFER cycles.
module bp_table_ctrl import bp_table_ctrl_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  bp_table_ctrl_if.slave  bus
);
  logic [1:0] pt_q        [PTENTRIES];
  logic       btb_valid_q [BTBENTRIES];
  tag_t       btb_tag_q   [BTBENTRIES];
  addr_t      btb_tgt_q   [BTBENTRIES];
  state_t     state_q, state_d;
  pt_idx_t    init_idx_q, init_idx_d;
  bhr_t       bhr_q, bhr_d;
  logic       full_q, full_d;
  upd_buf_t   buf_q, buf_d;
  defer_t     defer_q, defer_d;
  logic       init_busy_q, init_busy_d;
  logic       run, force_wr, lookup, wr, accept, hit;
  pt_idx_t    fe_pt_idx;
  btb_idx_t   fe_btb_idx;
  logic [1:0] ctr_nxt;
  logic       unused_pc;
  bp_sat_counter2 u_ctr (.cnt(pt_q[buf_q.pt_idx]), .inc(buf_q.taken), .nxt(ctr_nxt));
  always_comb begin
    run         = state_q == ST_RUN;
    force_wr    = run && full_q && defer_q == defer_t'(MAXDEFER);
    lookup      = run && !force_wr && bus.fe_req_valid && !bus.fe_stall;
    wr          = run && full_q && !lookup;
    accept      = bus.upd_valid && run && (!full_q || wr);
    fe_btb_idx  = btb_idx_of(bus.fe_pc);
    fe_pt_idx   = pt_base_of(bus.fe_pc) ^ pt_idx_t'(bhr_q);
    hit         = pt_q[fe_pt_idx][1] && btb_valid_q[fe_btb_idx] && btb_tag_q[fe_btb_idx] == tag_of(bus.fe_pc);
    state_d     = (state_q == ST_INIT && &init_idx_q) ? ST_RUN : state_q;
    init_idx_d  = run ? init_idx_q : init_idx_q + pt_idx_t'(1);
    init_busy_d = state_d == ST_INIT;
    bhr_d       = wr ? {bhr_q[BHRBITS-2:0], buf_q.taken} : bhr_q;
    full_d      = accept || (full_q && !wr);
    buf_d       = accept ? upd_buf_t'{pt_idx: bus.upd_pt_idx, btb_idx: btb_idx_of(bus.upd_pc),
                                      tag: tag_of(bus.upd_pc), taken: bus.upd_taken,
                                      target: bus.upd_target} : buf_q;
    defer_d     = (accept || wr || !full_q) ? '0 : defer_q + defer_t'(defer_q != defer_t'(MAXDEFER));
  end
  assign bus.pred_valid   = lookup;
  assign bus.pred_taken   = lookup && hit;
  assign bus.pred_target  = lookup ? btb_tgt_q[fe_btb_idx] : '0;
  assign bus.pred_pt_idx  = lookup ? fe_pt_idx : '0;
  assign bus.pred_btb_idx = lookup ? fe_btb_idx : '0;
  assign bus.upd_ready    = run && (!full_q || wr);
  assign bus.init_busy    = init_busy_q;
  // PC bits outside the index/tag fields never reach the tables
  assign unused_pc = ^{bus.fe_pc[1:0], bus.fe_pc[DBITS-1:BTBINDEXBITS+TAGBITS+2],
                       bus.upd_pc[1:0], bus.upd_pc[DBITS-1:BTBINDEXBITS+TAGBITS+2]};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      init_idx_q  <= '0;
      bhr_q       <= '0;
      full_q      <= 1'b0;
      buf_q       <= '0;
      defer_q     <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      bhr_q       <= bhr_d;
      full_q      <= full_d;
      buf_q       <= buf_d;
      defer_q     <= defer_d;
      init_busy_q <= init_busy_d;
    end
  end
  // Table storage has no reset; INIT walks it instead
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      pt_q[init_idx_q] <= PT_INIT;
      if (int'(init_idx_q) < BTBENTRIES) btb_valid_q[btb_idx_t'(init_idx_q)] <= 1'b0;
    end else if (wr) begin
      pt_q[buf_q.pt_idx] <= ctr_nxt;
      if (buf_q.taken) begin
        btb_valid_q[buf_q.btb_idx] <= 1'b1;
        btb_tag_q[buf_q.btb_idx]   <= buf_q.tag;
        btb_tgt_q[buf_q.btb_idx]   <= buf_q.target;
      end
    end
  end
endmodule

// File: tb/tb_bp_table_ctrl.sv
// tb_bp_table_ctrl: directed checks of init sequencing, arbitration, counters, BHR and BTB tags.
module tb_bp_table_ctrl;
  import bp_table_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset;
  bp_table_ctrl_if bus ();
  bp_table_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int passed = 0;
  logic     l_v, l_t;
  addr_t    l_tgt;
  pt_idx_t  l_pi;
  btb_idx_t l_bi;
  task automatic idle_inputs();
    bus.fe_req_valid = 1'b0;
    bus.fe_stall     = 1'b0;
    bus.fe_pc        = '0;
    bus.upd_valid    = 1'b0;
    bus.upd_pc       = '0;
    bus.upd_pt_idx   = '0;
    bus.upd_taken    = 1'b0;
    bus.upd_target   = '0;
  endtask
  task automatic wait_init(output int n);
    n = 0;
    while (bus.init_busy && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic look(input addr_t pc);
    bus.fe_req_valid = 1'b1;
    bus.fe_pc        = pc;
    #1;
    l_v   = bus.pred_valid;
    l_t   = bus.pred_taken;
    l_tgt = bus.pred_target;
    l_pi  = bus.pred_pt_idx;
    l_bi  = bus.pred_btb_idx;
    @(negedge clk);
    bus.fe_req_valid = 1'b0;
  endtask
  task automatic upd_one(input addr_t pc, input pt_idx_t idx, input logic tk, input addr_t tgt);
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_pt_idx = idx;
    bus.upd_taken  = tk;
    bus.upd_target = tgt;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    int n;
    reset = 1'b1;
    idle_inputs();
    #1 reset = 1'b0;
    bus.fe_req_valid = 1'b1;
    bus.fe_pc        = 32'h100;
    bus.upd_valid    = 1'b1;
    #1;
    checks++; if (bus.init_busy !== 1'b1) $display("FAIL reset_init_busy: got %0b want 1", bus.init_busy); else passed++;
    checks++; if (bus.pred_valid !== 1'b0) $display("FAIL reset_pred_valid: got %0b want 0", bus.pred_valid); else passed++;
    checks++; if (bus.pred_taken !== 1'b0) $display("FAIL reset_pred_taken: got %0b want 0", bus.pred_taken); else passed++;
    checks++; if (bus.pred_target !== '0) $display("FAIL reset_pred_target: got %h want 0", bus.pred_target); else passed++;
    checks++; if (bus.pred_pt_idx !== '0) $display("FAIL reset_pred_pt_idx: got %h want 0", bus.pred_pt_idx); else passed++;
    checks++; if (bus.upd_ready !== 1'b0) $display("FAIL reset_upd_ready: got %0b want 0", bus.upd_ready); else passed++;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_init(n);
    checks++; if (n !== 256) $display("FAIL init_len: got %0d want 256", n); else passed++;
    look(32'h1234);
    checks++; if (l_v !== 1'b1) $display("FAIL first_lookup_valid: got %0b want 1", l_v); else passed++;
    checks++; if (l_t !== 1'b0) $display("FAIL first_lookup_taken: got %0b want 0", l_t); else passed++;
    checks++; if (l_pi !== 8'h8D) $display("FAIL first_lookup_pt_idx: got %h want 8d", l_pi); else passed++;
    checks++; if (l_bi !== 6'h0D) $display("FAIL first_lookup_btb_idx: got %h want 0d", l_bi); else passed++;
  endtask
  task automatic test_init_restart();
    int n;
    reset = 1'b0;
    #1;
    checks++; if (bus.init_busy !== 1'b1) $display("FAIL rerst_init_busy: got %0b want 1", bus.init_busy); else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    bus.fe_req_valid = 1'b1;
    bus.upd_valid    = 1'b1;
    #1;
    checks++; if (bus.pred_valid !== 1'b0) $display("FAIL midinit_pred_valid: got %0b want 0", bus.pred_valid); else passed++;
    checks++; if (bus.upd_ready !== 1'b0) $display("FAIL midinit_upd_ready: got %0b want 0", bus.upd_ready); else passed++;
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_init(n);
    checks++; if (n !== 256) $display("FAIL restart_init_len: got %0d want 256", n); else passed++;
  endtask
  task automatic test_update();
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h100;
    bus.upd_pt_idx = 8'h43;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h200;
    #1;
    checks++; if (bus.upd_ready !== 1'b1) $display("FAIL upd_ready_empty: got %0b want 1", bus.upd_ready); else passed++;
    @(negedge clk);
    #1;
    checks++; if (bus.upd_ready !== 1'b1) $display("FAIL upd_ready_drain: got %0b want 1", bus.upd_ready); else passed++;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    @(negedge clk);
    look(32'h100);
    checks++; if (l_t !== 1'b1) $display("FAIL upd_taken: got %0b want 1", l_t); else passed++;
    checks++; if (l_tgt !== 32'h200) $display("FAIL upd_target: got %h want 00000200", l_tgt); else passed++;
    checks++; if (l_pi !== 8'h43) $display("FAIL upd_pt_idx: got %h want 43", l_pi); else passed++;
    checks++; if (l_bi !== 6'h00) $display("FAIL upd_btb_idx: got %h want 00", l_bi); else passed++;
  endtask
  task automatic test_forced_write();
    bus.fe_req_valid = 1'b1;
    bus.fe_pc        = 32'h100;
    bus.upd_valid    = 1'b1;
    bus.upd_pc       = 32'h100;
    bus.upd_pt_idx   = 8'h43;
    bus.upd_taken    = 1'b1;
    bus.upd_target   = 32'h200;
    #1;
    checks++; if (bus.upd_ready !== 1'b1) $display("FAIL force_accept: got %0b want 1", bus.upd_ready); else passed++;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (bus.pred_valid !== 1'b1) $display("FAIL force_lookup%0d_valid: got %0b want 1", k, bus.pred_valid); else passed++;
      checks++; if (bus.pred_taken !== 1'b1) $display("FAIL force_lookup%0d_taken: got %0b want 1", k, bus.pred_taken); else passed++;
      @(negedge clk);
    end
    #1;
    checks++; if (bus.pred_valid !== 1'b0) $display("FAIL force_write_pred_valid: got %0b want 0", bus.pred_valid); else passed++;
    checks++; if (bus.upd_ready !== 1'b1) $display("FAIL force_write_upd_ready: got %0b want 1", bus.upd_ready); else passed++;
    @(negedge clk);
    bus.fe_req_valid = 1'b0;
  endtask
  task automatic test_sat_low();
    upd_one(32'h100, 8'h31, 1'b0, 32'h200);
    upd_one(32'h100, 8'h31, 1'b0, 32'h200);
    upd_one(32'h100, 8'h31, 1'b0, 32'h200);
    upd_one(32'h100, 8'h31, 1'b1, 32'h200);
    look(32'h100);
    checks++; if (l_pi !== 8'h31) $display("FAIL sat_low_pt_idx: got %h want 31", l_pi); else passed++;
    checks++; if (l_t !== 1'b0) $display("FAIL sat_low_taken: got %0b want 0", l_t); else passed++;
  endtask
  task automatic test_sat_high();
    upd_one(32'h100, 8'h5E, 1'b1, 32'h200);
    upd_one(32'h100, 8'h5E, 1'b1, 32'h200);
    upd_one(32'h100, 8'h5E, 1'b1, 32'h200);
    upd_one(32'h100, 8'h5E, 1'b0, 32'h200);
    look(32'h100);
    checks++; if (l_pi !== 8'h5E) $display("FAIL sat_high_pt_idx: got %h want 5e", l_pi); else passed++;
    checks++; if (l_t !== 1'b1) $display("FAIL sat_high_taken: got %0b want 1", l_t); else passed++;
  endtask
  task automatic test_bhr();
    repeat (8) upd_one(32'h100, 8'hFF, 1'b1, 32'h200);
    look(32'h100);
    checks++; if (l_pi !== 8'hBF) $display("FAIL bhr_ff_pt_idx: got %h want bf", l_pi); else passed++;
    upd_one(32'h100, 8'hFF, 1'b0, 32'h200);
    look(32'h100);
    checks++; if (l_pi !== 8'hBE) $display("FAIL bhr_fe_pt_idx: got %h want be", l_pi); else passed++;
  endtask
  task automatic test_alias();
    upd_one(32'h200, 8'hBD, 1'b1, 32'h300);
    look(32'h100);
    checks++; if (l_pi !== 8'hBD) $display("FAIL alias_pt_idx: got %h want bd", l_pi); else passed++;
    checks++; if (l_bi !== 6'h00) $display("FAIL alias_btb_idx: got %h want 00", l_bi); else passed++;
    checks++; if (l_t !== 1'b0) $display("FAIL alias_taken: got %0b want 0", l_t); else passed++;
  endtask
  initial begin
    test_reset();
    test_init_restart();
    test_update();
    test_forced_write();
    test_sat_low();
    test_sat_high();
    test_bhr();
    test_alias();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
